// File: rtl/fetch_ctrl_v_if.sv
// Handshake bundle between the fetch sequencer and its environment.
// The slave modport is the sequencer's view; master is the driver/hazard side.
interface fetch_ctrl_v_if;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        is_stall;
  logic        is_flush;
  logic [31:0] fetch_count;

  modport master (
    output stall_in, redirect_valid, redirect_pc, halt_req,
    input  imem_addr, imem_en, pc_out, valid_out, is_stall, is_flush, fetch_count
  );

  modport slave (
    input  stall_in, redirect_valid, redirect_pc, halt_req,
    output imem_addr, imem_en, pc_out, valid_out, is_stall, is_flush, fetch_count
  );
endinterface

// File: rtl/fetch_ctrl_v.sv
// Fetch-stage sequencer: owns the PC, drives the synchronous imem port and
// produces IF/ID controls aligned to the memory's one-cycle read latency.
module fetch_ctrl_v #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          PC_STEP      = 4,
  parameter int          FLUSH_CYCLES = 1
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_v_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_out_q;
  logic        valid_q;
  logic [31:0] fetch_cnt_q;
  logic [3:0]  flush_cnt;

  logic redirect_hit;
  logic fetch_go;

  // A redirect wins over halt and stall everywhere except the terminal state.
  assign redirect_hit = bus.redirect_valid & (state != HALT);
  assign fetch_go     = (state == RUN) & ~bus.redirect_valid & ~bus.halt_req & ~bus.stall_in;

  assign bus.imem_addr   = pc;
  assign bus.imem_en     = fetch_go;
  assign bus.is_stall    = (state == RUN) & bus.stall_in & ~bus.redirect_valid & ~bus.halt_req;
  assign bus.is_flush    = (state == BOOT) | (state == FLUSH) | redirect_hit;
  assign bus.pc_out      = pc_out_q;
  assign bus.valid_out   = valid_q;
  assign bus.fetch_count = fetch_cnt_q;

  // NOTE: state is updated with non-blocking assignments so every register in
  // this block samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pc_out_q    <= 32'h0;
      valid_q     <= 1'b0;
      fetch_cnt_q <= 32'h0;
      flush_cnt   <= 4'h0;
    end else if (redirect_hit) begin
      // Reloading the counter here also restarts an in-progress flush.
      state     <= FLUSH;
      pc        <= bus.redirect_pc & ~32'h3;
      valid_q   <= 1'b0;
      flush_cnt <= 4'(FLUSH_CYCLES - 1);
    end else begin
      unique case (state)
        BOOT: begin
          state   <= RUN;
          valid_q <= 1'b0;
        end
        RUN: begin
          if (bus.halt_req) begin
            state   <= HALT;
            valid_q <= 1'b0;
          end else if (!bus.stall_in) begin
            pc          <= pc + 32'(PC_STEP);
            pc_out_q    <= pc;
            valid_q     <= 1'b1;
            fetch_cnt_q <= fetch_cnt_q + 32'h1;
          end
        end
        FLUSH: begin
          valid_q <= 1'b0;
          if (flush_cnt == 4'h0) state <= RUN;
          else                   flush_cnt <= flush_cnt - 4'h1;
        end
        HALT: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl_v.sv
// Self-checking bench: two sequencers (flush windows 1 and 3) share one
// stimulus stream and are compared each cycle against a behavioural model.
module tb_fetch_ctrl_v;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_ctrl_v_if u_if1 ();
  fetch_ctrl_v_if u_if3 ();

  fetch_ctrl_v #(.RESET_PC(32'h0), .PC_STEP(4), .FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(u_if1.slave)
  );
  fetch_ctrl_v #(.RESET_PC(32'h0), .PC_STEP(4), .FLUSH_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(u_if3.slave)
  );

  localparam int FL [2] = '{1, 3};

  // Model: remaining flush cycles, boot pending, halted, plus architectural values.
  typedef struct {
    bit          boot;
    int          flush_left;
    bit          halted;
    logic [31:0] pc;
    logic [31:0] pc_out;
    bit          valid;
    logic [31:0] cnt;
  } mdl_t;

  mdl_t m [2];

  logic        st, rv, hr;
  logic [31:0] rpc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] p, input logic h);
    st = s; rv = r; rpc = p; hr = h;
    u_if1.stall_in = s; u_if1.redirect_valid = r; u_if1.redirect_pc = p; u_if1.halt_req = h;
    u_if3.stall_in = s; u_if3.redirect_valid = r; u_if3.redirect_pc = p; u_if3.halt_req = h;
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].boot = 1'b1; m[i].flush_left = 0; m[i].halted = 1'b0;
      m[i].pc = 32'h0; m[i].pc_out = 32'h0; m[i].valid = 1'b0; m[i].cnt = 32'h0;
    end
  endfunction

  function automatic void mdl_update();
    for (int i = 0; i < 2; i++) begin
      if (m[i].halted) begin
        m[i].valid = 1'b0;
      end else if (rv) begin
        m[i].pc = {rpc[31:2], 2'b00};
        m[i].valid = 1'b0;
        m[i].flush_left = FL[i];
        m[i].boot = 1'b0;
      end else if (m[i].boot) begin
        m[i].boot = 1'b0;
        m[i].valid = 1'b0;
      end else if (m[i].flush_left > 0) begin
        m[i].flush_left--;
        m[i].valid = 1'b0;
      end else if (hr) begin
        m[i].halted = 1'b1;
        m[i].valid = 1'b0;
      end else if (!st) begin
        m[i].pc_out = m[i].pc;
        m[i].pc = m[i].pc + 32'd4;
        m[i].valid = 1'b1;
        m[i].cnt = m[i].cnt + 32'd1;
      end
    end
  endfunction

  task automatic compare_all();
    logic [31:0] o_addr [2], o_pco [2], o_cnt [2];
    logic        o_en [2], o_val [2], o_stl [2], o_fls [2];
    bit running, e_stl, e_fls, e_en;
    o_addr[0] = u_if1.imem_addr; o_en[0] = u_if1.imem_en; o_pco[0] = u_if1.pc_out;
    o_val[0] = u_if1.valid_out; o_stl[0] = u_if1.is_stall; o_fls[0] = u_if1.is_flush;
    o_cnt[0] = u_if1.fetch_count;
    o_addr[1] = u_if3.imem_addr; o_en[1] = u_if3.imem_en; o_pco[1] = u_if3.pc_out;
    o_val[1] = u_if3.valid_out; o_stl[1] = u_if3.is_stall; o_fls[1] = u_if3.is_flush;
    o_cnt[1] = u_if3.fetch_count;
    for (int i = 0; i < 2; i++) begin
      running = !m[i].halted && !m[i].boot && m[i].flush_left == 0;
      e_stl   = running && st && !rv && !hr;
      e_en    = running && !st && !rv && !hr;
      e_fls   = !m[i].halted && (m[i].boot || m[i].flush_left > 0 || rv);
      check($sformatf("f%0d.imem_addr", FL[i]),   o_addr[i], m[i].pc);
      check($sformatf("f%0d.imem_en", FL[i]),     32'(o_en[i]), 32'(e_en));
      check($sformatf("f%0d.is_stall", FL[i]),    32'(o_stl[i]), 32'(e_stl));
      check($sformatf("f%0d.is_flush", FL[i]),    32'(o_fls[i]), 32'(e_fls));
      check($sformatf("f%0d.pc_out", FL[i]),      o_pco[i], m[i].pc_out);
      check($sformatf("f%0d.valid_out", FL[i]),   32'(o_val[i]), 32'(m[i].valid));
      check($sformatf("f%0d.fetch_count", FL[i]), o_cnt[i], m[i].cnt);
    end
  endtask

  // One clock cycle: drive after the edge, compare mid-cycle, advance the model on the edge.
  task automatic step(input logic s, input logic r, input logic [31:0] p, input logic h);
    drive(s, r, p, h);
    @(negedge clk);
    compare_all();
    @(posedge clk);
    mdl_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Reset lands mid-cycle; outputs are checked before the next clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    mdl_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();

    // Boot then sequential fetches 0x0..0xC, leaving pc at 0x10.
    idle(5);

    // Three-cycle stall at pc 0x10, then release.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b0);
    idle(2);

    // Redirect to 0x103 during a stall.
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    idle(6);

    // Redirect to 0x200, then a second redirect to 0x300 two cycles later.
    step(1'b0, 1'b1, 32'h0000_0200, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0300, 1'b0);
    idle(6);

    // PC wrap through the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    idle(6);

    // Asynchronous reset while flushing.
    step(1'b0, 1'b1, 32'h0000_0500, 1'b0);
    do_reset();
    idle(3);

    // Halt together with a redirect: redirect wins, held halt taken afterwards.
    step(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0080, 1'b0);
    idle(2);
    do_reset();
    idle(3);

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ((m[0].halted || m[1].halted) && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 12,
             $urandom(), $urandom_range(0, 99) < 3);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
